// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types.
//   word_t     : 32-bit architectural data word
//   regbits_t  : 5-bit register index (r0..r31, r0 reads as zero)
//   wb_entry_t : one pending register-file write (destination + data)
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef struct packed {
    regbits_t wsel;
    word_t    wdat;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO of register-file write entries, used to park long-latency-unit
// results until the rf write port is free.
// Ports:
//   CLK, RST     : clock, asynchronous active-high reset
//   push, din    : enqueue din (caller never pushes when full)
//   pop, dout    : dequeue; dout is the current head (valid when !empty)
//   full, empty  : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_fifo
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t din,
  output wb_entry_t dout,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  wb_entry_t     mem_q [DEPTH];

  // NOTE: combinational blocks use blocking assignments and assign every
  // output first, so no latch is inferred; flops below use non-blocking only.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    // Simultaneous push and pop leave the count unchanged.
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the count guards every read, so
  // stale contents are never observed and the array stays plain RAM.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-side master for the 32x32 register file. Merges in-order pipeline
// writeback and long-latency-unit (mul/div) results onto the single rf write
// port, and tracks which registers still await an LU result.
// Ports:
//   CLK, RST                     : clock, asynchronous active-high reset
//   pipe_wen/pipe_wsel/pipe_wdat : pipeline writeback (always has priority)
//   lu_valid/lu_wsel/lu_wdat     : LU result, transferred when lu_ready=1
//   lu_ready                     : result FIFO not full
//   iss_valid/iss_wsel           : LU op issue, marks destination pending
//   chk_rsel1/2, chk_busy1/2     : decode pending lookup (combinational)
//   rf_WEN/rf_wsel/rf_wdat       : registered rf write port
module regfile_wb_arbiter
  import cpu_types_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic     CLK,
  input  logic     RST,
  input  logic     pipe_wen,
  input  regbits_t pipe_wsel,
  input  word_t    pipe_wdat,
  input  logic     lu_valid,
  input  regbits_t lu_wsel,
  input  word_t    lu_wdat,
  output logic     lu_ready,
  input  logic     iss_valid,
  input  regbits_t iss_wsel,
  input  regbits_t chk_rsel1,
  input  regbits_t chk_rsel2,
  output logic     chk_busy1,
  output logic     chk_busy2,
  output logic     rf_WEN,
  output regbits_t rf_wsel,
  output word_t    rf_wdat
);

  logic      fifo_full, fifo_empty, fifo_push, fifo_pop;
  wb_entry_t fifo_head, lu_entry;
  logic      pipe_act;

  logic        rf_wen_q, rf_wen_d;
  regbits_t    rf_wsel_q, rf_wsel_d;
  word_t       rf_wdat_q, rf_wdat_d;
  // Remembers that the current rf write came from the FIFO, so the matching
  // pending bit is cleared on the edge the register file captures it.
  logic        rf_from_fifo_q, rf_from_fifo_d;
  logic [31:0] pending_q, pending_d;

  // No same-cycle pop credit: readiness depends on the stored count only.
  assign lu_ready = !fifo_full;
  // Results for r0 complete the handshake but are never queued.
  assign fifo_push = lu_valid && !fifo_full && (lu_wsel != '0);
  assign lu_entry  = '{wsel: lu_wsel, wdat: lu_wdat};

  // A pipe write to r0 is not a write, so the FIFO may use the port.
  assign pipe_act = pipe_wen && (pipe_wsel != '0);
  assign fifo_pop = !pipe_act && !fifo_empty;

  wb_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (lu_entry),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    rf_wen_d       = 1'b0;
    rf_wsel_d      = rf_wsel_q;
    rf_wdat_d      = rf_wdat_q;
    rf_from_fifo_d = 1'b0;
    if (pipe_act) begin
      rf_wen_d  = 1'b1;
      rf_wsel_d = pipe_wsel;
      rf_wdat_d = pipe_wdat;
    end else if (fifo_pop) begin
      rf_wen_d       = 1'b1;
      rf_wsel_d      = fifo_head.wsel;
      rf_wdat_d      = fifo_head.wdat;
      rf_from_fifo_d = 1'b1;
    end

    // Clear first, then set, so a same-edge re-issue keeps the bit.
    pending_d = pending_q;
    if (rf_wen_q && rf_from_fifo_q) pending_d[rf_wsel_q] = 1'b0;
    if (iss_valid && (iss_wsel != '0)) pending_d[iss_wsel] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rf_wen_q       <= 1'b0;
      rf_wsel_q      <= '0;
      rf_wdat_q      <= '0;
      rf_from_fifo_q <= 1'b0;
      pending_q      <= '0;
    end else begin
      rf_wen_q       <= rf_wen_d;
      rf_wsel_q      <= rf_wsel_d;
      rf_wdat_q      <= rf_wdat_d;
      rf_from_fifo_q <= rf_from_fifo_d;
      pending_q      <= pending_d;
    end
  end

  assign chk_busy1 = pending_q[chk_rsel1];
  assign chk_busy2 = pending_q[chk_rsel2];
  assign rf_WEN    = rf_wen_q;
  assign rf_wsel   = rf_wsel_q;
  assign rf_wdat   = rf_wdat_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a queue-based
// reference model of the write-port arbitration and pending scoreboard.
module tb_regfile_wb_arbiter;
  import cpu_types_pkg::*;

  localparam int QD = 2;

  logic     CLK = 1'b0;
  logic     RST;
  logic     pipe_wen;
  regbits_t pipe_wsel;
  word_t    pipe_wdat;
  logic     lu_valid;
  regbits_t lu_wsel;
  word_t    lu_wdat;
  logic     lu_ready;
  logic     iss_valid;
  regbits_t iss_wsel;
  regbits_t chk_rsel1, chk_rsel2;
  logic     chk_busy1, chk_busy2;
  logic     rf_WEN;
  regbits_t rf_wsel;
  word_t    rf_wdat;

  regfile_wb_arbiter #(.QDEPTH(QD)) dut (
    .CLK(CLK), .RST(RST),
    .pipe_wen(pipe_wen), .pipe_wsel(pipe_wsel), .pipe_wdat(pipe_wdat),
    .lu_valid(lu_valid), .lu_wsel(lu_wsel), .lu_wdat(lu_wdat), .lu_ready(lu_ready),
    .iss_valid(iss_valid), .iss_wsel(iss_wsel),
    .chk_rsel1(chk_rsel1), .chk_rsel2(chk_rsel2),
    .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
    .rf_WEN(rf_WEN), .rf_wsel(rf_wsel), .rf_wdat(rf_wdat)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a queue of parked LU results, a pending flag per
  // register, and the last write the register file was offered.
  wb_entry_t m_q[$];
  bit        m_pend [32];
  bit        m_wen;
  bit [4:0]  m_wsel;
  bit [31:0] m_wdat;
  bit        m_last_from_lu;

  task automatic model_reset();
    m_q.delete();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_wen = 1'b0; m_wsel = '0; m_wdat = '0; m_last_from_lu = 1'b0;
  endtask

  task automatic drive(input bit pw, input bit [4:0] ps, input bit [31:0] pd,
                       input bit lv, input bit [4:0] ls, input bit [31:0] ld,
                       input bit iv, input bit [4:0] is,
                       input bit [4:0] r1, input bit [4:0] r2);
    pipe_wen = pw; pipe_wsel = ps; pipe_wdat = pd;
    lu_valid = lv; lu_wsel = ls; lu_wdat = ld;
    iss_valid = iv; iss_wsel = is;
    chk_rsel1 = r1; chk_rsel2 = r2;
  endtask

  // One clock: check combinational outputs, advance the model across the
  // edge using the inputs that were stable there, then check rf outputs.
  task automatic step();
    bit        accept;
    wb_entry_t e;
    #1;
    check("lu_ready", {31'b0, lu_ready}, {31'b0, m_q.size() < QD});
    check("chk_busy1", {31'b0, chk_busy1}, {31'b0, m_pend[chk_rsel1]});
    check("chk_busy2", {31'b0, chk_busy2}, {31'b0, m_pend[chk_rsel2]});
    @(posedge CLK);
    accept = lu_valid && (m_q.size() < QD);
    if (m_wen && m_last_from_lu) m_pend[m_wsel] = 1'b0;
    if (iss_valid && iss_wsel != 0) m_pend[iss_wsel] = 1'b1;
    if (pipe_wen && pipe_wsel != 0) begin
      m_wen = 1'b1; m_wsel = pipe_wsel; m_wdat = pipe_wdat; m_last_from_lu = 1'b0;
    end else if (m_q.size() > 0) begin
      e = m_q.pop_front();
      m_wen = 1'b1; m_wsel = e.wsel; m_wdat = e.wdat; m_last_from_lu = 1'b1;
    end else begin
      m_wen = 1'b0; m_last_from_lu = 1'b0;
    end
    if (accept && lu_wsel != 0) m_q.push_back('{wsel: lu_wsel, wdat: lu_wdat});
    #1;
    check("rf_WEN", {31'b0, rf_WEN}, {31'b0, m_wen});
    check("rf_wsel", {27'b0, rf_wsel}, {27'b0, m_wsel});
    check("rf_wdat", rf_wdat, m_wdat);
  endtask

  task automatic idle(input int n, input bit [4:0] r1, input bit [4:0] r2);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, r1, r2);
      step();
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    RST = 1'b1;
    model_reset();
    #12;
    check("rst_wen", {31'b0, rf_WEN}, 32'd0);
    check("rst_wsel", {27'b0, rf_wsel}, 32'd0);
    check("rst_wdat", rf_wdat, 32'd0);
    check("rst_lu_ready", {31'b0, lu_ready}, 32'd1);
    #2 RST = 1'b0;
    @(posedge CLK); #1;

    // Pipe only, then a pipe write to r0 which must not reach the rf.
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0); step();
    check("pipe_wdat", rf_wdat, 32'hDEADBEEF);
    drive(1, 0, 32'h12345678, 0, 0, 0, 0, 0, 0, 0); step();
    check("pipe_r0_wen", {31'b0, rf_WEN}, 32'd0);

    // LU r7 queued behind three cycles of pipe writes.
    drive(1, 1, 32'hA1, 1, 7, 32'h11, 1, 7, 7, 0); step();
    drive(1, 2, 32'hA2, 0, 0, 0, 0, 0, 7, 0); step();
    drive(1, 3, 32'hA3, 0, 0, 0, 0, 0, 7, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 7, 0); step();
    check("lu_r7_wsel", {27'b0, rf_wsel}, 32'd7);
    check("lu_r7_wdat", rf_wdat, 32'h11);
    idle(2, 7, 0);

    // Fill the FIFO under continuous pipe writes, then release.
    drive(1, 1, 32'hB1, 1, 3, 32'h33, 0, 0, 0, 0); step();
    drive(1, 2, 32'hB2, 1, 4, 32'h44, 0, 0, 0, 0); step();
    drive(1, 1, 32'hB3, 1, 5, 32'h55, 0, 0, 0, 0); step();
    check("full_lu_ready", {31'b0, lu_ready}, 32'd0);
    idle(4, 0, 0);

    // Scoreboard r9 with a re-issue on the clearing edge.
    drive(0, 0, 0, 0, 0, 0, 1, 9, 9, 0); step();
    idle(2, 9, 0);
    drive(0, 0, 0, 1, 9, 32'h99, 0, 0, 9, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 9, 0); step();
    drive(0, 0, 0, 0, 0, 0, 1, 9, 9, 0); step();
    #1 check("reissue_busy1", {31'b0, chk_busy1}, 32'd1);
    drive(0, 0, 0, 1, 9, 32'h98, 0, 0, 9, 0); step();
    idle(3, 9, 0);

    // Register 0 everywhere: nothing pending, nothing written.
    drive(0, 0, 0, 1, 0, 32'hFF, 1, 0, 0, 0); step();
    idle(2, 0, 0);

    // Reset mid-drain with two results queued and a register pending.
    drive(1, 1, 32'hC1, 1, 6, 32'h66, 1, 6, 6, 6); step();
    drive(1, 2, 32'hC2, 1, 8, 32'h88, 1, 8, 6, 8); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 6, 8); step();
    #2 RST = 1'b1;
    #1;
    check("mid_rst_wen", {31'b0, rf_WEN}, 32'd0);
    check("mid_rst_lu_ready", {31'b0, lu_ready}, 32'd1);
    check("mid_rst_busy1", {31'b0, chk_busy1}, 32'd0);
    check("mid_rst_busy2", {31'b0, chk_busy2}, 32'd0);
    model_reset();
    #1 RST = 1'b0;

    // Randomized traffic on a small register window to force collisions.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 99) < 45, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 99) < 50, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 99) < 30, 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      step();
    end
    idle(4, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
